// File: rtl/deque_arb_pkg.sv
// Package for the shared deque controller.
// Holds the opcode encoding seen on each requester's req_op field and small
// decode helpers shared by the top level.
package deque_arb_pkg;

  localparam int unsigned OpWidth = 3;

  typedef enum logic [OpWidth-1:0] {
    OpPushBack  = 3'd0,
    OpPushFront = 3'd1,
    OpPopBack   = 3'd2,
    OpPopFront  = 3'd3,
    OpGet       = 3'd4
  } op_e;

  // Encodings 5..7 are reserved and answered with an error response.
  function automatic logic op_is_illegal(logic [OpWidth-1:0] op);
    return op > OpWidth'(OpGet);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Ports:
//   req_i       - request vector, one bit per requester
//   rr_ptr_i    - requester index that has highest priority this cycle
//   gnt_o       - one-hot grant (all zero when no request)
//   gnt_idx_o   - binary index of the granted requester (0 when none)
//   gnt_valid_o - a grant was issued
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned IDW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDW-1:0]     rr_ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDW-1:0]     gnt_idx_o,
  output logic               gnt_valid_o
);

  always_comb begin
    int unsigned cand;
    logic [IDW-1:0] cand_idx;
    logic found;
    cand        = 0;
    cand_idx    = '0;
    found       = 1'b0;
    gnt_o       = '0;
    gnt_idx_o   = '0;
    gnt_valid_o = 1'b0;
    // Scan starting at rr_ptr_i, wrapping; first hit wins.
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand     = (32'(rr_ptr_i) + k) % NUM_REQ;
      cand_idx = IDW'(cand);
      if (!found && req_i[cand_idx]) begin
        found           = 1'b1;
        gnt_o[cand_idx] = 1'b1;
        gnt_idx_o       = cand_idx;
        gnt_valid_o     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/deque_port_arbiter.sv
// Shared double-ended queue with a round-robin request port per agent.
// Ports:
//   clk, rst      - clock and synchronous active-high reset
//   flush         - clears the deque contents; blocks all grants that cycle
//   req_valid     - per-requester request valid
//   req_op        - per-requester opcode (3 bits each, see deque_arb_pkg)
//   req_idx       - per-requester GET index, 0 = front
//   req_data      - per-requester push data
//   req_ready     - one-hot grant; a request transfers on valid & ready
//   rsp_valid     - one-cycle response strobe, cycle after acceptance
//   rsp_id        - requester being answered
//   rsp_data      - popped / read element, 0 for pushes and errors
//   rsp_err       - request rejected without state change
//   count         - current occupancy
//   full, empty   - occupancy flags derived from count
module deque_port_arbiter
  import deque_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned DEPTH   = 16,
  localparam int unsigned IDXW   = $clog2(DEPTH),
  localparam int unsigned CNTW   = $clog2(DEPTH + 1),
  localparam int unsigned IDW    = $clog2(NUM_REQ)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*OpWidth-1:0] req_op,
  input  logic [NUM_REQ*IDXW-1:0]    req_idx,
  input  logic [NUM_REQ*WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       rsp_valid,
  output logic [IDW-1:0]             rsp_id,
  output logic [WIDTH-1:0]           rsp_data,
  output logic                       rsp_err,
  output logic [CNTW-1:0]            count,
  output logic                       full,
  output logic                       empty
);

  // Deque state. head points at the front element, tail one past the back;
  // both wrap naturally because DEPTH is a power of two.
  logic [IDXW-1:0]  head_q, head_d;
  logic [IDXW-1:0]  tail_q, tail_d;
  logic [CNTW-1:0]  count_q, count_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;

  logic             rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]   rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_err_q, rsp_err_d;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             mem_we;
  logic [IDXW-1:0]  mem_waddr;
  logic [WIDTH-1:0] mem_wdata;
  logic [IDXW-1:0]  rd_addr;

  // Arbitration. Reset and flush suppress every request so no grant is seen.
  logic [NUM_REQ-1:0] arb_req;
  logic [NUM_REQ-1:0] gnt;
  logic [IDW-1:0]     gnt_idx;
  logic               gnt_valid;

  assign arb_req = (rst || flush) ? '0 : req_valid;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .req_i       (arb_req),
    .rr_ptr_i    (rr_ptr_q),
    .gnt_o       (gnt),
    .gnt_idx_o   (gnt_idx),
    .gnt_valid_o (gnt_valid)
  );

  assign req_ready = gnt;

  // Fields of the granted requester.
  logic [OpWidth-1:0] sel_op;
  logic [IDXW-1:0]    sel_idx;
  logic [WIDTH-1:0]   sel_data;

  assign sel_op   = req_op[32'(gnt_idx) * OpWidth +: OpWidth];
  assign sel_idx  = req_idx[32'(gnt_idx) * IDXW +: IDXW];
  assign sel_data = req_data[32'(gnt_idx) * WIDTH +: WIDTH];

  logic full_c, empty_c, idx_in_range;

  assign full_c       = (count_q == CNTW'(DEPTH));
  assign empty_c      = (count_q == '0);
  assign idx_in_range = (CNTW'(sel_idx) < count_q);

  always_comb begin
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    rr_ptr_d    = rr_ptr_q;
    rsp_valid_d = 1'b0;
    rsp_id_d    = '0;
    rsp_data_d  = '0;
    rsp_err_d   = 1'b0;
    mem_we      = 1'b0;
    mem_waddr   = tail_q;
    mem_wdata   = sel_data;
    rd_addr     = head_q;

    if (gnt_valid) begin
      rsp_valid_d = 1'b1;
      rsp_id_d    = gnt_idx;
      // Errored requests still consume their turn.
      rr_ptr_d    = (gnt_idx == IDW'(NUM_REQ - 1)) ? '0 : gnt_idx + IDW'(1);

      if (op_is_illegal(sel_op)) begin
        rsp_err_d = 1'b1;
      end else begin
        case (op_e'(sel_op))
          OpPushBack: begin
            if (full_c) begin
              rsp_err_d = 1'b1;
            end else begin
              mem_we    = 1'b1;
              mem_waddr = tail_q;
              tail_d    = tail_q + IDXW'(1);
              count_d   = count_q + CNTW'(1);
            end
          end
          OpPushFront: begin
            if (full_c) begin
              rsp_err_d = 1'b1;
            end else begin
              mem_we    = 1'b1;
              mem_waddr = head_q - IDXW'(1);
              head_d    = head_q - IDXW'(1);
              count_d   = count_q + CNTW'(1);
            end
          end
          OpPopBack: begin
            if (empty_c) begin
              rsp_err_d = 1'b1;
            end else begin
              rd_addr    = tail_q - IDXW'(1);
              rsp_data_d = mem_q[rd_addr];
              tail_d     = tail_q - IDXW'(1);
              count_d    = count_q - CNTW'(1);
            end
          end
          OpPopFront: begin
            if (empty_c) begin
              rsp_err_d = 1'b1;
            end else begin
              rd_addr    = head_q;
              rsp_data_d = mem_q[rd_addr];
              head_d     = head_q + IDXW'(1);
              count_d    = count_q - CNTW'(1);
            end
          end
          OpGet: begin
            if (!idx_in_range) begin
              rsp_err_d = 1'b1;
            end else begin
              rd_addr    = head_q + sel_idx;
              rsp_data_d = mem_q[rd_addr];
            end
          end
          default: begin
            rsp_err_d = 1'b1;
          end
        endcase
      end
    end

    // No grant is possible during flush, so only the pointers need clearing.
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      rr_ptr_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      rr_ptr_q    <= rr_ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Storage is not reset; mem_we is already blocked while rst is high.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign count     = count_q;
  assign full      = full_c;
  assign empty     = empty_c;

endmodule
